// File: rtl/pong_vga_renderer.sv
// rtl/pong_vga_renderer.sv - 640x480@60Hz VGA raster that renders the pong game state
// Game inputs are latched once per frame (hcnt 0, vcnt 480) so every displayed frame is coherent.
module pong_vga_renderer #(
  parameter int CLK_DIV = 2,
  parameter int PAD_W   = 10,
  parameter int BALL_R  = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [9:0] ballX,
  input  logic [9:0] ballY,
  input  logic [9:0] plat1X,
  input  logic [9:0] plat1Y,
  input  logic [9:0] plat2X,
  input  logic [9:0] plat2Y,
  input  logic [9:0] plat1H,
  input  logic [9:0] plat2H,
  input  logic [4:0] Score_1,
  input  logic [4:0] Score_2,
  input  logic       WIN1,
  input  logic       WIN2,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       frameTick
);

  localparam logic [1:0] DIV_MAX = 2'(CLK_DIV - 1);

  typedef struct packed {
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] p1_x;
    logic [9:0] p1_y;
    logic [9:0] p1_h;
    logic [9:0] p2_x;
    logic [9:0] p2_y;
    logic [9:0] p2_h;
    logic [4:0] score1;
    logic [4:0] score2;
    logic       win1;
    logic       win2;
  } game_t;

  typedef struct packed {
    logic ball;
    logic p1;
    logic p2;
    logic score;
    logic net;
    logic vis;
    logic hs;
    logic vs;
    logic win1;
    logic win2;
  } pix_t;

  localparam pix_t ST1_RST = '{hs: 1'b1, vs: 1'b1, default: 1'b0};

  logic [1:0]  div_q, div_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  game_t       shadow_q, shadow_d;
  pix_t        st1_q, st1_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  logic        pix_en;
  logic        load;
  game_t       game_in;
  pix_t        hit;
  logic [10:0] h11, v11, bdx, bdy, s1_lo, s2_hi;

  // Stage 0: pixel divider, raster counters and the once-per-frame shadow load
  always_comb begin
    pix_en = (div_q == DIV_MAX);
    div_d  = pix_en ? 2'd0 : div_q + 2'd1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      if (hcnt_q == 10'd799) begin
        hcnt_d = 10'd0;
        vcnt_d = (vcnt_q == 10'd524) ? 10'd0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
    game_in   = '{ballX, ballY, plat1X, plat1Y, plat1H, plat2X, plat2Y, plat2H,
                  Score_1, Score_2, WIN1, WIN2};
    load      = pix_en && (hcnt_q == 10'd0) && (vcnt_q == 10'd480);
    shadow_d  = load ? game_in : shadow_q;
    frameTick = load;
  end

  // Stage 1: hit tests in 11 bits so wrapped (negative) coordinates never alias onto the screen
  always_comb begin
    h11   = {1'b0, hcnt_q};
    v11   = {1'b0, vcnt_q};
    bdx   = h11 + 11'(BALL_R) - {1'b0, shadow_q.ball_x};
    bdy   = v11 + 11'(BALL_R) - {1'b0, shadow_q.ball_y};
    s1_lo = 11'd630 - {3'b000, shadow_q.score1, 3'b000};
    s2_hi = 11'd10 + {3'b000, shadow_q.score2, 3'b000};

    hit.ball  = (bdx < 11'(2 * BALL_R)) && (bdy < 11'(2 * BALL_R));
    hit.p1    = (h11 >= {1'b0, shadow_q.p1_x}) && (h11 < {1'b0, shadow_q.p1_x} + 11'(PAD_W)) &&
                (v11 >= {1'b0, shadow_q.p1_y}) && (v11 < {1'b0, shadow_q.p1_y} + {1'b0, shadow_q.p1_h});
    hit.p2    = (h11 >= {1'b0, shadow_q.p2_x}) && (h11 < {1'b0, shadow_q.p2_x} + 11'(PAD_W)) &&
                (v11 >= {1'b0, shadow_q.p2_y}) && (v11 < {1'b0, shadow_q.p2_y} + {1'b0, shadow_q.p2_h});
    hit.score = (vcnt_q >= 10'd4) && (vcnt_q < 10'd12) &&
                (((h11 >= s1_lo) && (h11 < 11'd630)) || ((h11 >= 11'd10) && (h11 < s2_hi)));
    hit.net   = ((hcnt_q == 10'd319) || (hcnt_q == 10'd320)) && !vcnt_q[4];
    hit.vis   = (hcnt_q < 10'd640) && (vcnt_q < 10'd480);
    hit.hs    = !((hcnt_q >= 10'd656) && (hcnt_q < 10'd752));
    hit.vs    = !((vcnt_q >= 10'd490) && (vcnt_q < 10'd492));
    hit.win1  = shadow_q.win1;
    hit.win2  = shadow_q.win2;

    st1_d = pix_en ? hit : st1_q;
  end

  // Stage 2: colour priority and blanking
  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (pix_en) begin
      hs_d = st1_q.hs;
      vs_d = st1_q.vs;
      if (!st1_q.vis)       rgb_d = 12'h000;
      else if (st1_q.ball)  rgb_d = 12'hFFF;
      else if (st1_q.p1)    rgb_d = 12'hF00;
      else if (st1_q.p2)    rgb_d = 12'h00F;
      else if (st1_q.score) rgb_d = 12'h0F0;
      else if (st1_q.net)   rgb_d = 12'h888;
      else                  rgb_d = {st1_q.win1 ? 4'h4 : 4'h0, 4'h0, st1_q.win2 ? 4'h4 : 4'h0};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q    <= 2'd0;
      hcnt_q   <= 10'd0;
      vcnt_q   <= 10'd0;
      shadow_q <= '0;
      st1_q    <= ST1_RST;
      rgb_q    <= 12'h000;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      div_q    <= div_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      shadow_q <= shadow_d;
      st1_q    <= st1_d;
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  assign VGA_HS = hs_q;
  assign VGA_VS = vs_q;
  assign VGA_R  = rgb_q[11:8];
  assign VGA_G  = rgb_q[7:4];
  assign VGA_B  = rgb_q[3:0];

endmodule

// File: tb/tb_pong_vga_renderer.sv
// tb/tb_pong_vga_renderer.sv - scoreboard bench for pong_vga_renderer against a per-pixel reference model
// Dead raster stretches are skipped by loading the raster counters directly, keeping runs short.
module tb_pong_vga_renderer;
  localparam int CLK_DIV = 2;
  localparam int PAD_W   = 10;
  localparam int BALL_R  = 5;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [9:0] ballX, ballY, plat1X, plat1Y, plat2X, plat2Y, plat1H, plat2H;
  logic [4:0] Score_1, Score_2;
  logic       WIN1, WIN2;
  logic       VGA_HS, VGA_VS;
  logic [3:0] VGA_R, VGA_G, VGA_B;
  logic       frameTick;

  pong_vga_renderer #(.CLK_DIV(CLK_DIV), .PAD_W(PAD_W), .BALL_R(BALL_R)) dut (
    .CLK(CLK), .RESET(RESET),
    .ballX(ballX), .ballY(ballY),
    .plat1X(plat1X), .plat1Y(plat1Y), .plat2X(plat2X), .plat2Y(plat2Y),
    .plat1H(plat1H), .plat2H(plat2H),
    .Score_1(Score_1), .Score_2(Score_2), .WIN1(WIN1), .WIN2(WIN2),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .frameTick(frameTick)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    int bx, by, p1x, p1y, p1h, p2x, p2y, p2h, s1, s2, w1, w2;
  } gs_t;

  typedef struct {
    int          x, y;
    logic [13:0] v;
  } exp_t;

  exp_t       sb[$];
  gs_t        shadow;
  int         mx, my, div, loads, ft_seen;
  int         n_cmp, n_fail;
  logic [9:0] jx, jy;
  event       tick_e;

  function automatic gs_t zero_gs();
    gs_t g = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    return g;
  endfunction

  function automatic gs_t cur_inputs();
    gs_t g;
    g.bx = ballX;   g.by = ballY;
    g.p1x = plat1X; g.p1y = plat1Y; g.p1h = plat1H;
    g.p2x = plat2X; g.p2y = plat2Y; g.p2h = plat2H;
    g.s1 = Score_1; g.s2 = Score_2;
    g.w1 = WIN1;    g.w2 = WIN2;
    return g;
  endfunction

  function automatic logic [11:0] colour(gs_t g, int x, int y);
    int dx = x + BALL_R - g.bx;
    int dy = y + BALL_R - g.by;
    if (dx >= 0 && dx < 2 * BALL_R && dy >= 0 && dy < 2 * BALL_R) return 12'hFFF;
    if (x >= g.p1x && x < g.p1x + PAD_W && y >= g.p1y && y < g.p1y + g.p1h) return 12'hF00;
    if (x >= g.p2x && x < g.p2x + PAD_W && y >= g.p2y && y < g.p2y + g.p2h) return 12'h00F;
    if (y >= 4 && y < 12 && ((x >= 630 - 8 * g.s1 && x < 630) || (x >= 10 && x < 10 + 8 * g.s2)))
      return 12'h0F0;
    if ((x == 319 || x == 320) && ((y / 16) % 2 == 0)) return 12'h888;
    return {(g.w1 != 0) ? 4'h4 : 4'h0, 4'h0, (g.w2 != 0) ? 4'h4 : 4'h0};
  endfunction

  function automatic logic [13:0] expect_px(gs_t g, int x, int y);
    logic hs = !(x >= 656 && x < 752);
    logic vs = !(y >= 490 && y < 492);
    return {hs, vs, (x < 640 && y < 480) ? colour(g, x, y) : 12'h000};
  endfunction

  // Reference raster: one expected output per pixel tick, delivered two ticks late via the queue
  initial begin
    exp_t e;
    loads = 0;
    forever begin
      @(posedge CLK);
      if (RESET) begin
        div = 0; mx = 0; my = 0;
        shadow = zero_gs();
        sb.delete();
        e.x = -1; e.y = -1; e.v = 14'h3000;
        sb.push_back(e);
      end else if (div == CLK_DIV - 1) begin
        div = 0;
        e.x = mx; e.y = my; e.v = expect_px(shadow, mx, my);
        sb.push_back(e);
        if (mx == 0 && my == 480) begin
          shadow = cur_inputs();
          loads++;
        end
        mx++;
        if (mx == 800) begin
          mx = 0;
          my = (my == 524) ? 0 : my + 1;
        end
        -> tick_e;
      end else begin
        div++;
      end
    end
  end

  // Monitor
  initial begin
    exp_t        e;
    logic [13:0] got;
    ft_seen = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (frameTick) ft_seen++;
        if (sb.size() > 1) begin
          e   = sb.pop_front();
          got = {VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B};
          n_cmp++;
          if (got !== e.v) begin
            n_fail++;
            $display("FAIL pixel (%0d,%0d): got hs=%0d vs=%0d rgb=%03h, want hs=%0d vs=%0d rgb=%03h",
                     e.x, e.y, got[13], got[12], got[11:0], e.v[13], e.v[12], e.v[11:0]);
          end
        end
      end
    end
  end

  task automatic chk(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_hs"}, int'(VGA_HS), 1);
    chk({tag, "_vs"}, int'(VGA_VS), 1);
    chk({tag, "_rgb"}, int'({VGA_R, VGA_G, VGA_B}), 0);
    chk({tag, "_tick"}, int'(frameTick), 0);
  endtask

  task automatic set_game(int bx, int by, int p1x, int p1y, int p1h, int p2x, int p2y, int p2h,
                          int s1, int s2, int w1, int w2);
    @(negedge CLK);
    ballX = 10'(bx);   ballY = 10'(by);
    plat1X = 10'(p1x); plat1Y = 10'(p1y); plat1H = 10'(p1h);
    plat2X = 10'(p2x); plat2Y = 10'(p2y); plat2H = 10'(p2h);
    Score_1 = 5'(s1);  Score_2 = 5'(s2);
    WIN1 = w1[0];      WIN2 = w2[0];
  endtask

  task automatic rand_game();
    set_game($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 660),
             $urandom_range(0, 500), $urandom_range(0, 200), $urandom_range(0, 660),
             $urandom_range(0, 500), $urandom_range(0, 200), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  task automatic wait_ticks(int n);
    repeat (n) @(tick_e);
  endtask

  // Relocate the raster; held across a non-pixel edge so the counters settle on (x,y)
  task automatic jump(int x, int y);
    @(tick_e);
    @(negedge CLK);
    jx = 10'(x);
    jy = 10'(y);
    force dut.hcnt_q = jx;
    force dut.vcnt_q = jy;
    mx = x;
    my = y;
    @(negedge CLK);
    release dut.hcnt_q;
    release dut.vcnt_q;
  endtask

  task automatic visit(int x, int y, int n);
    jump(x, y);
    wait_ticks(n);
  endtask

  // Pass through the shadow load, scramble the inputs, then wrap into the new frame
  task automatic load_frame();
    visit(760, 479, 60);
    rand_game();
    visit(760, 524, 60);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: run exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rand_game();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk_reset_outputs("reset");
    RESET = 1'b0;

    // Frame 0 renders zeroed shadows whatever the inputs are doing
    repeat (3) begin
      rand_game();
      wait_ticks(800);
    end

    set_game(625, 240, 620, 220, 40, 100, 300, 50, 3, 15, 0, 0);
    load_frame();
    visit(0, 4, 660);
    visit(600, 220, 60);
    visit(600, 240, 60);
    visit(600, 259, 60);
    visit(600, 260, 60);
    visit(90, 300, 40);
    visit(760, 489, 1700);

    set_game(320, 240, $urandom_range(0, 200), $urandom_range(300, 400), 30,
             $urandom_range(400, 600), 0, 20, 0, $urandom_range(1, 31), 1, 0);
    load_frame();
    visit(0, 4, 660);
    for (int r = 234; r <= 245; r++) visit(300, r, 40);

    set_game(1019, $urandom_range(0, 479), 700, 0, 0, 700, 0, 0,
             $urandom_range(0, 31), $urandom_range(0, 31), 1, 1);
    load_frame();
    visit(0, 4, 660);
    for (int r = 0; r < 4; r++) visit(0, $urandom_range(0, 479), 660);

    // Asynchronous reset in mid-frame; WIN1 only shows once it has been loaded
    visit(100, 300, 50);
    @(posedge CLK);
    #3;
    RESET = 1'b1;
    WIN1 = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    wait_ticks(1700);
    set_game($urandom_range(0, 1023), $urandom_range(0, 1023), 700, 0, 0, 700, 0, 0, 0, 0, 1, 0);
    load_frame();
    visit(0, 100, 700);

    repeat (2) begin
      rand_game();
      load_frame();
      visit(0, 4, 660);
      for (int r = 0; r < 4; r++) visit(0, $urandom_range(0, 479), 660);
    end

    chk("frame_ticks", ft_seen, loads);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_vga_renderer.md
# pong_vga_renderer

Scan-out side of the game-state interface. Consumes the ball, platform, score and win outputs of the game logic and drives a 640x480@60 Hz VGA raster with 4-bit-per-channel colour. Samples all game coordinates once per frame into shadow registers so each displayed frame is coherent. Sits between the game core and the DE0 VGA pins.

## Interface
- CLK_DIV, 2, CLK cycles per pixel (50 MHz CLK -> 25 MHz pixel rate); legal 1..4
- PAD_W, 10, platform width in pixels
- BALL_R, 5, ball half-size; ball is a (2*BALL_R)x(2*BALL_R) square
- CLK  in  1  system clock; the only clock
- RESET  in  1  asynchronous, active-high reset
- ballX, ballY  in  10 each  ball centre
- plat1X, plat1Y, plat2X, plat2Y  in  10 each  platform top-left corners
- plat1H, plat2H  in  10 each  platform heights
- Score_1, Score_2  in  5 each  player scores (0..31 accepted, 15 is max in play)
- WIN1, WIN2  in  1 each  win flags
- VGA_HS, VGA_VS  out  1 each  syncs, active-low
- VGA_R, VGA_G, VGA_B  out  4 each  colour
- frameTick  out  1  one-CLK pulse when shadow registers load

## Operation
- Pixel enable: divider counts 0..CLK_DIV-1; pix_en high when count == CLK_DIV-1. All counters/pipeline advance only on pix_en.
- hcnt 0..799, wraps to 0 and increments vcnt; vcnt 0..524, wraps to 0.
- Horizontal: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799. Vertical: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Shadow load: on pix_en with hcnt==0, vcnt==480, all 12 game inputs copied to shadow registers; frameTick high that same CLK. Input changes at any other time never affect the current frame.
- Hit tests (using shadow values, 11-bit arithmetic, no truncation):
  - ball: hcnt+BALL_R-ballX in [0, 2*BALL_R) and same for vcnt/ballY. Out-of-range/wrapped ball values (e.g. 1019 from a -5 position) simply produce no hit.
  - platform n: hcnt in [platnX, platnX+PAD_W) and vcnt in [platnY, platnY+platnH).
  - score 1 bar: vcnt in [4,12), hcnt in [630-8*Score_1, 630); score 2 bar: vcnt in [4,12), hcnt in [10, 10+8*Score_2). Score 0 draws nothing.
  - net: hcnt in {319,320} and vcnt[4]==0.
- Colour priority: ball FFF > platform 1 F00 > platform 2 00F > score bars 0F0 > net 888 > background.
- Background: 000; 400 if WIN1 only; 004 if WIN2 only; 404 if both.
- Outside visible area RGB forced to 000 regardless of hits.

## Timing
- Pipeline: stage 0 counters, stage 1 registered hit flags + visible flag + raw syncs, stage 2 registered RGB/HS/VS. Outputs lag counter value by exactly 2 pixel ticks; syncs and RGB stay aligned.
- Outputs change only on CLK edges coincident with pix_en.
- Frame period 800*525 pixel ticks = 420000*CLK_DIV CLK cycles.
- Reset (any time, including mid-line): divider, hcnt, vcnt = 0; VGA_HS=VGA_VS=1; RGB=000; frameTick=0; all shadow registers 0; pipeline cleared. After release, first frame shows shadow zeros until first load at vcnt 480 (ball/platforms only appear if hit at zero coordinates).
- Simultaneous shadow load and input change: value present on the load CLK edge is captured.

## Test plan
- Sync timing, CLK_DIV=2: after reset, measure HS low for 192 CLK every 1600 CLK; VS low for 2 lines (3200 CLK) every 840000 CLK; first HS fall 2 ticks after hcnt reaches 656.
- Ball render: ballX=320, ballY=240 loaded; pixels (315..324, 235..244) FFF, (314,240) and (325,240) not FFF; ballX=1019 -> no ball pixels anywhere.
- Priority/platforms: plat1X=620, plat1Y=220, plat1H=40; ball at (625,240) -> overlap pixels FFF, (620,220) F00, (630,220) background, (620,260) background.
- Score bars: Score_1=3, Score_2=15 -> row 4 green at x 606..629 and 10..129; Score_1=0 -> no green on right.
- Frame coherence: change ballX from 100 to 200 at vcnt 100 -> remainder of frame shows ball at 100; next frame at 200; frameTick exactly one pulse per frame.
- Reset mid-frame at vcnt 300: outputs go HS=VS=1, RGB=000 asynchronously; after release raster restarts at (0,0), WIN1=1 background 400 appears only after next shadow load.
